tdc_conv_sequencer: RTL and testbench

//  Per-pixel TDC conversion controller. Sequences one hit through the TOA/TOT capture path.

---
 rtl/tdc_conv_sequencer.sv | 100 ++++++++++
 tb/tb_tdc_conv_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_conv_sequencer.sv
// tdc_conv_sequencer: sequences one pixel hit through TOA latch, TOT latch, encode and readout handshake
module tdc_conv_sequencer #(
  parameter int LATCH_DLY   = 2,
  parameter int ENC_LAT     = 3,
  parameter int TOT_TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cal_mode,
  input  logic       hit_rise,
  input  logic       hit_fall,
  output logic       toa_latch,
  output logic       tot_latch,
  output logic       enc_start,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       tot_timeout,
  output logic       busy,
  output logic [7:0] hit_lost_cnt
);
  typedef enum logic [2:0] {IDLE, TOA_WAIT, TOT_WAIT, ENCODE, HOLD} state_t;
  localparam logic [7:0] DLY_LOAD = 8'((LATCH_DLY > 1) ? LATCH_DLY - 2 : 0);
  localparam logic [7:0] ENC_LOAD = 8'(ENC_LAT - 1);
  localparam logic [7:0] TO_LIM   = 8'(TOT_TIMEOUT);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, lost_n;
  logic fall_seen, fall_n, toa_n, tot_n, valid_n, to_n;
  logic early_end;
  assign early_end = cal_mode | fall_seen | hit_fall;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fall_n  = fall_seen;
    toa_n   = 1'b0;
    tot_n   = 1'b0;
    valid_n = data_valid;
    to_n    = tot_timeout;
    lost_n  = (hit_rise && (state != IDLE || !enable) && hit_lost_cnt != 8'hFF) ? hit_lost_cnt + 8'd1 : hit_lost_cnt;
    case (state)
      IDLE: if (hit_rise && enable) begin
        fall_n  = hit_fall;
        toa_n   = (LATCH_DLY == 1);
        state_n = (LATCH_DLY == 1) ? TOT_WAIT : TOA_WAIT;
        cnt_n   = (LATCH_DLY == 1) ? 8'd0 : DLY_LOAD;
      end
      TOA_WAIT: begin
        fall_n  = fall_seen | hit_fall;
        toa_n   = (cnt == 8'd0);
        state_n = (cnt == 8'd0) ? TOT_WAIT : TOA_WAIT;
        cnt_n   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      end
      TOT_WAIT: if (early_end || cnt == TO_LIM) begin
        tot_n   = 1'b1;
        to_n    = !early_end;
        state_n = ENCODE;
        cnt_n   = ENC_LOAD;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      ENCODE: begin
        valid_n = (cnt == 8'd0);
        state_n = (cnt == 8'd0) ? HOLD : ENCODE;
        cnt_n   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      end
      HOLD: if (data_valid && data_ready) begin
        valid_n = 1'b0;
        to_n    = 1'b0;
        fall_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      fall_seen    <= 1'b0;
      toa_latch    <= 1'b0;
      tot_latch    <= 1'b0;
      enc_start    <= 1'b0;
      data_valid   <= 1'b0;
      tot_timeout  <= 1'b0;
      busy         <= 1'b0;
      hit_lost_cnt <= 8'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      fall_seen    <= fall_n;
      toa_latch    <= toa_n;
      tot_latch    <= tot_n;
      enc_start    <= tot_n;
      data_valid   <= valid_n;
      tot_timeout  <= to_n;
      busy         <= (state_n != IDLE);
      hit_lost_cnt <= lost_n;
    end
  end
endmodule

// File: tb/tb_tdc_conv_sequencer.sv
// tb_tdc_conv_sequencer: directed stimulus with a queued event scoreboard checked by a negedge monitor
module tb_tdc_conv_sequencer;
  logic clk = 0, reset = 1, enable = 0, cal_mode = 0, hit_rise = 0, hit_fall = 0, data_ready = 0;
  logic toa_latch, tot_latch, enc_start, data_valid, tot_timeout, busy;
  logic [7:0] hit_lost_cnt;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int kind; int at; bit to;} ev_t;
  ev_t q[$];
  logic prev_valid = 0, prev_to = 0;

  tdc_conv_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .cal_mode(cal_mode),
    .hit_rise(hit_rise), .hit_fall(hit_fall), .toa_latch(toa_latch),
    .tot_latch(tot_latch), .enc_start(enc_start), .data_valid(data_valid),
    .data_ready(data_ready), .tot_timeout(tot_timeout), .busy(busy),
    .hit_lost_cnt(hit_lost_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic see(input int kind, input bit to);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d: got event expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == 2 && e.to != to)) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d to=%0d expected kind=%0d cyc=%0d to=%0d",
                 kind, cyc, to, e.kind, e.at, e.to);
      end
    end
  endtask

  always @(negedge clk) begin
    if (toa_latch) see(0, 1'b0);
    if (tot_latch) begin
      see(1, 1'b0);
      chk("enc_start_with_tot", int'(enc_start), 1);
    end
    if (data_valid && !prev_valid) see(2, tot_timeout);
    if (data_valid && prev_valid) chk("hold_tot_timeout_stable", int'(tot_timeout), int'(prev_to));
    prev_valid <= data_valid;
    prev_to    <= tot_timeout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_ev(input int kind, input int c, input bit to);
    q.push_back('{kind, c, to});
  endtask

  task automatic pulse(input int c, input bit r, input bit f);
    at(c);
    hit_rise = r;
    hit_fall = f;
    tick();
    hit_rise = 0;
    hit_fall = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || data_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_within_bound", int'(busy || data_valid), 0);
  endtask

  int b;
  initial begin
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_lost", int'(hit_lost_cnt), 0);
    chk("rst_timeout", int'(tot_timeout), 0);
    enable = 1;
    data_ready = 1;
    tick();
    // nominal
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 7, 0); expect_ev(2, b + 10, 0);
    pulse(b, 1, 0);
    chk("nom_busy_c1", int'(busy), 1);
    pulse(b + 6, 0, 1);
    at(b + 10);
    chk("nom_busy_c10", int'(busy), 1);
    tick();
    chk("nom_busy_c11", int'(busy), 0);
    chk("nom_valid_c11", int'(data_valid), 0);
    tick();
    // early fall
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 3, 0); expect_ev(2, b + 6, 0);
    pulse(b, 1, 0);
    pulse(b + 1, 0, 1);
    wait_idle();
    tick();
    // rise and fall in the same cycle
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 3, 0); expect_ev(2, b + 6, 0);
    pulse(b, 1, 1);
    wait_idle();
    tick();
    // timeout
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 15, 0); expect_ev(2, b + 18, 1);
    pulse(b, 1, 0);
    wait_idle();
    chk("timeout_cleared", int'(tot_timeout), 0);
    tick();
    // cal mode ignores the fall and latches TOT right after TOA
    cal_mode = 1;
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 3, 0); expect_ev(2, b + 6, 0);
    pulse(b, 1, 0);
    wait_idle();
    cal_mode = 0;
    tick();
    // backpressure with lost hits
    data_ready = 0;
    b = cyc;
    expect_ev(0, b + 2, 0); expect_ev(1, b + 3, 0); expect_ev(2, b + 6, 0);
    pulse(b, 1, 0);
    pulse(b + 1, 0, 1);
    pulse(b + 8, 1, 0);
    pulse(b + 12, 1, 0);
    pulse(b + 16, 1, 0);
    at(b + 20);
    chk("bp_valid_held", int'(data_valid), 1);
    chk("bp_lost3", int'(hit_lost_cnt), 3);
    data_ready = 1;
    tick();
    chk("bp_valid_drop", int'(data_valid), 0);
    chk("bp_idle", int'(busy), 0);
    // saturation while disabled
    enable = 0;
    hit_rise = 1;
    repeat (247) tick();
    chk("lost_250", int'(hit_lost_cnt), 250);
    chk("disabled_no_start", int'(busy), 0);
    repeat (53) tick();
    hit_rise = 0;
    chk("lost_sat", int'(hit_lost_cnt), 255);
    enable = 1;
    tick();
    // reset during TOT_WAIT
    b = cyc;
    expect_ev(0, b + 2, 0);
    pulse(b, 1, 0);
    at(b + 4);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_lost", int'(hit_lost_cnt), 0);
    chk("mid_rst_latches", int'({toa_latch, tot_latch, enc_start, data_valid, tot_timeout}), 0);
    expect_ev(0, b + 8, 0); expect_ev(1, b + 10, 0); expect_ev(2, b + 13, 0);
    pulse(b + 6, 1, 0);
    pulse(b + 9, 0, 1);
    wait_idle();
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
